// File: rtl/regarb_pkg.sv
// Shared definitions for the register-file write arbiter: requester indices,
// FSM state encoding and small index helpers.
package regarb_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_ALU    = 2'd0;
    localparam logic [1:0] REQ_MEM    = 2'd1;
    localparam logic [1:0] REQ_IMM    = 2'd2;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FROZEN = 2'd2
    } arb_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = GRANT_NONE;
        if (oh[0]) begin
            idx = REQ_ALU;
        end else if (oh[1]) begin
            idx = REQ_MEM;
        end else if (oh[2]) begin
            idx = REQ_IMM;
        end
        return idx;
    endfunction

    function automatic logic [1:0] next_rr(input logic [1:0] idx);
        logic [1:0] nxt;
        nxt = (idx == REQ_IMM) ? REQ_ALU : idx + 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/regarb_rr_select.sv
// Picks one pending requester: round-robin from rr_i, or fixed priority
// IMM > MEM > ALU when REGARB_FIXED_PRIO_EN is defined (rr_i then ignored).
module regarb_rr_select
    import regarb_pkg::*;
(
    input  logic [2:0] pending_i,
    input  logic [1:0] rr_i,
    output logic [2:0] grant_o
);

`ifdef REGARB_FIXED_PRIO_EN
    always_comb begin
        grant_o = 3'b000;
        if (pending_i[REQ_IMM]) begin
            grant_o[REQ_IMM] = 1'b1;
        end else if (pending_i[REQ_MEM]) begin
            grant_o[REQ_MEM] = 1'b1;
        end else if (pending_i[REQ_ALU]) begin
            grant_o[REQ_ALU] = 1'b1;
        end
    end
`else
    logic [2:0] first_oh;
    logic [2:0] second_oh;
    logic [2:0] third_oh;

    // Search order is a rotation of ALU, MEM, IMM starting at rr_i.
    always_comb begin
        first_oh  = 3'b001;
        second_oh = 3'b010;
        third_oh  = 3'b100;
        case (rr_i)
            2'd1: begin
                first_oh  = 3'b010;
                second_oh = 3'b100;
                third_oh  = 3'b001;
            end
            2'd2: begin
                first_oh  = 3'b100;
                second_oh = 3'b001;
                third_oh  = 3'b010;
            end
            default: begin
                first_oh  = 3'b001;
                second_oh = 3'b010;
                third_oh  = 3'b100;
            end
        endcase
    end

    always_comb begin
        grant_o = 3'b000;
        if (|(pending_i & first_oh)) begin
            grant_o = first_oh;
        end else if (|(pending_i & second_oh)) begin
            grant_o = second_oh;
        end else if (|(pending_i & third_oh)) begin
            grant_o = third_oh;
        end
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU/MEM/IMM write-back requests onto a single register-file write
// port. Build option: REGARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int dataSize = 8,
    parameter int numReg   = 2
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [2:0]                ReqValid,
    output logic [2:0]                ReqReady,
    input  logic [3*numReg-1:0]       ReqAddr,
    input  logic [3*dataSize-1:0]     ReqData,
    input  logic                      Freeze,
    output logic [numReg-1:0]         WriteReg,
    output logic [dataSize-1:0]       WriteData,
    output logic                      RegWriteCtrl,
    output logic                      LoadImm,
    output logic [1:0]                GrantId,
    output logic                      Idle,
    output arb_state_e                DbgState
);

    // Handshake: a requester transfers when ReqValid[i] and ReqReady[i] are both
    // high at a rising CLK edge; ReqReady never depends on ReqValid.

    logic [2:0]          pend_q, pend_d;
    logic [numReg-1:0]   addr_q [NUM_REQ];
    logic [numReg-1:0]   addr_d [NUM_REQ];
    logic [dataSize-1:0] data_q [NUM_REQ];
    logic [dataSize-1:0] data_d [NUM_REQ];
    arb_state_e          state_q, state_d;
    logic [1:0]          rr_sel;
    logic [2:0]          sel;
    logic [2:0]          grant;
    logic [2:0]          accept;
    logic [1:0]          gidx;

`ifdef REGARB_FIXED_PRIO_EN
    assign rr_sel = 2'd0;
`else
    logic [1:0] rr_q, rr_d;
    assign rr_sel = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (|grant) begin
            rr_d = next_rr(gidx);
        end
    end
`endif

    regarb_rr_select u_select (
        .pending_i (pend_q),
        .rr_i      (rr_sel),
        .grant_o   (sel)
    );

    assign grant    = Freeze ? 3'b000 : sel;
    assign gidx     = onehot_to_idx(grant);
    assign ReqReady = Reset ? 3'b000 : (~pend_q | grant);
    assign accept   = ReqValid & ReqReady;

    // A fresh accept on the grant edge reloads the buffer instead of clearing it.
    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                pend_d[i] = 1'b1;
                addr_d[i] = ReqAddr[i*numReg +: numReg];
                data_d[i] = ReqData[i*dataSize +: dataSize];
            end else if (grant[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend_d) begin
                    state_d = Freeze ? ST_FROZEN : ST_ACTIVE;
                end
            end
            ST_ACTIVE, ST_FROZEN: begin
                if (!(|pend_d)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = Freeze ? ST_FROZEN : ST_ACTIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        RegWriteCtrl = |grant;
        LoadImm      = grant[REQ_IMM];
        GrantId      = gidx;
        WriteReg     = '0;
        WriteData    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                WriteReg  = WriteReg | addr_q[i];
                WriteData = WriteData | data_q[i];
            end
        end
    end

    assign Idle     = (state_q == ST_IDLE);
    assign DbgState = state_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pend_q  <= 3'b000;
            state_q <= ST_IDLE;
`ifndef REGARB_FIXED_PRIO_EN
            rr_q    <= 2'd0;
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            state_q <= state_d;
`ifndef REGARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes queued at issue
// time, popped by a monitor on every cycle RegWriteCtrl is high.
module tb_regfile_write_arbiter;
    import regarb_pkg::*;

    localparam int DW = 8;
    localparam int NR = 2;
    localparam int EW = NR + DW + 3;

    logic            CLK;
    logic            Reset;
    logic [2:0]      ReqValid;
    logic [2:0]      ReqReady;
    logic [3*NR-1:0] ReqAddr;
    logic [3*DW-1:0] ReqData;
    logic            Freeze;
    logic [NR-1:0]   WriteReg;
    logic [DW-1:0]   WriteData;
    logic            RegWriteCtrl;
    logic            LoadImm;
    logic [1:0]      GrantId;
    logic            Idle;
    arb_state_e      DbgState;

    int              n_chk;
    int              n_fail;
    logic [EW-1:0]   exp_q[$];
    logic [DW-1:0]   regs[4];
    logic            sb_en;
    logic [EW-1:0]   act_w;
    logic [EW-1:0]   exp_w;

    regfile_write_arbiter #(
        .dataSize (DW),
        .numReg   (NR)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqAddr      (ReqAddr),
        .ReqData      (ReqData),
        .Freeze       (Freeze),
        .WriteReg     (WriteReg),
        .WriteData    (WriteData),
        .RegWriteCtrl (RegWriteCtrl),
        .LoadImm      (LoadImm),
        .GrantId      (GrantId),
        .Idle         (Idle),
        .DbgState     (DbgState)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [EW-1:0] wr(input logic [NR-1:0] a, input logic [DW-1:0] d,
                                         input logic li, input logic [1:0] g);
        return {a, d, li, g};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Present requests on the masked ports for exactly one accept edge.
    task automatic issue(input logic [2:0] mask, input logic [3*NR-1:0] addr,
                         input logic [3*DW-1:0] data);
        ReqAddr  = addr;
        ReqData  = data;
        ReqValid = mask;
        @(negedge CLK);
        chk("accept_ready", ReqReady & mask, mask);
        step(1);
        ReqValid = 3'b000;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, ReqReady, 3'b000);
        chk({tag, "_wen"}, RegWriteCtrl, 1'b0);
        chk({tag, "_limm"}, LoadImm, 1'b0);
        chk({tag, "_wreg"}, WriteReg, 0);
        chk({tag, "_wdata"}, WriteData, 0);
        chk({tag, "_gid"}, GrantId, 2'd3);
        chk({tag, "_idle"}, Idle, 1'b1);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        sb_en    = 1'b1;
        Reset    = 1'b1;
        ReqValid = 3'b000;
        ReqAddr  = '0;
        ReqData  = '0;
        Freeze   = 1'b0;
        for (int i = 0; i < 4; i++) regs[i] = '0;

        fork
            begin : stimulus
                step(2);
                chk_reset_outputs("rst_hold");
                Reset = 1'b0;
                step(1);
                chk("post_reset_ready", ReqReady, 3'b111);
                chk("post_reset_state", DbgState, ST_IDLE);

                // Three simultaneous requests from rr=0
`ifdef REGARB_FIXED_PRIO_EN
                exp_q.push_back(wr(2'd3, 8'd7, 1'b1, 2'd2));
                exp_q.push_back(wr(2'd2, 8'd6, 1'b0, 2'd1));
                exp_q.push_back(wr(2'd1, 8'd5, 1'b0, 2'd0));
`else
                exp_q.push_back(wr(2'd1, 8'd5, 1'b0, 2'd0));
                exp_q.push_back(wr(2'd2, 8'd6, 1'b0, 2'd1));
                exp_q.push_back(wr(2'd3, 8'd7, 1'b1, 2'd2));
`endif
                issue(3'b111, {2'd3, 2'd2, 2'd1}, {8'd7, 8'd6, 8'd5});
                @(negedge CLK);
                chk("busy_after_accept", Idle, 1'b0);
                repeat (3) @(posedge CLK);
                @(negedge CLK);
                chk("idle_after_drain", Idle, 1'b1);
                step(1);

                // Single ALU request, rr=0
                exp_q.push_back(wr(2'd2, 8'd10, 1'b0, 2'd0));
                issue(3'b001, {2'd0, 2'd0, 2'd2}, {8'd0, 8'd0, 8'd10});
                @(negedge CLK);
                chk("alu_latency_wen", RegWriteCtrl, 1'b1);
                chk("alu_latency_gid", GrantId, 2'd0);
                step(1);

                // Back-to-back accept into ALU while it drains
                exp_q.push_back(wr(2'd0, 8'h11, 1'b0, 2'd0));
                exp_q.push_back(wr(2'd1, 8'h22, 1'b0, 2'd0));
                issue(3'b001, {2'd0, 2'd0, 2'd0}, {8'd0, 8'd0, 8'h11});
                issue(3'b001, {2'd0, 2'd0, 2'd1}, {8'd0, 8'd0, 8'h22});
                step(3);

                // MEM pending under a 4-cycle freeze
                Freeze = 1'b1;
                exp_q.push_back(wr(2'd1, 8'h33, 1'b0, 2'd1));
                issue(3'b010, {2'd0, 2'd1, 2'd0}, {8'd0, 8'h33, 8'd0});
                for (int k = 0; k < 4; k++) begin
                    @(negedge CLK);
                    chk("freeze_wen", RegWriteCtrl, 1'b0);
                    chk("freeze_gid", GrantId, 2'd3);
                end
                chk("freeze_mem_ready", ReqReady[1], 1'b0);
                step(1);
                Freeze = 1'b0;
                @(negedge CLK);
                chk("unfreeze_wen", RegWriteCtrl, 1'b1);
                chk("unfreeze_gid", GrantId, 2'd1);
                step(1);

                // ALU and IMM to the same register, rr=2: IMM first, ALU last
                exp_q.push_back(wr(2'd3, 8'd9, 1'b1, 2'd2));
                exp_q.push_back(wr(2'd3, 8'd1, 1'b0, 2'd0));
                issue(3'b101, {2'd3, 2'd0, 2'd3}, {8'd9, 8'd0, 8'd1});
                step(3);
                chk("same_addr_last", regs[3], 8'd1);

                // Asynchronous reset with two frozen requests pending
                Freeze = 1'b1;
                issue(3'b011, {2'd0, 2'd2, 2'd1}, {8'd0, 8'h44, 8'h55});
                @(negedge CLK);
                chk("frozen_idle", Idle, 1'b0);
                chk("frozen_ready", ReqReady, 3'b100);
                step(1);
                #1 Reset = 1'b1;
                #1 chk_reset_outputs("async_rst");
                step(2);
                Reset  = 1'b0;
                Freeze = 1'b0;
                repeat (5) @(negedge CLK);
                chk("rst_discard_idle", Idle, 1'b1);
                step(1);

`ifdef REGARB_FIXED_PRIO_EN
                // ALU held valid; each IMM pulse must win the next cycle
                sb_en    = 1'b0;
                ReqAddr  = {2'd2, 2'd0, 2'd0};
                ReqData  = {8'hC0, 8'd0, 8'hA0};
                ReqValid = 3'b001;
                for (int k = 0; k < 3; k++) begin
                    step(2);
                    ReqValid[2] = 1'b1;
                    step(1);
                    ReqValid[2] = 1'b0;
                    @(negedge CLK);
                    chk("fixed_imm_gid", GrantId, 2'd2);
                    chk("fixed_imm_limm", LoadImm, 1'b1);
                end
                ReqValid = 3'b000;
                step(4);
                sb_en = 1'b1;
`endif

                chk("queue_drain", exp_q.size(), 0);
            end
            begin : monitor
                forever begin
                    @(negedge CLK);
                    if (!Reset && RegWriteCtrl && sb_en) begin
                        act_w = {WriteReg, WriteData, LoadImm, GrantId};
                        // All-ones can never be a legal write (GrantId=3 with enable high).
                        exp_w = (exp_q.size() == 0) ? {EW{1'b1}} : exp_q.pop_front();
                        chk("write", act_w, exp_w);
                        regs[WriteReg] = WriteData;
                    end
                end
            end
        join_any
        disable fork;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter dataSize, default 8, register data width.
REQ-002 SHALL have parameter numReg, default 2, register address width.
REQ-003 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ReqValid  input  3  per-requester valid: bit0 ALU, bit1 MEM, bit2 IMM.
REQ-006 SHALL have port ReqReady  output  3  per-requester ready.
REQ-007 SHALL have port ReqAddr  input  3 x numReg  per-requester destination register.
REQ-008 SHALL have port ReqData  input  3 x dataSize  per-requester write data.
REQ-009 SHALL have port Freeze  input  1  pipeline stall, suppresses grants.
REQ-010 SHALL have port WriteReg  output  numReg  register file write address.
REQ-011 SHALL have port WriteData  output  dataSize  register file write data.
REQ-012 SHALL have port RegWriteCtrl  output  1  register file write enable.
REQ-013 SHALL have port LoadImm  output  1  high when granted requester is IMM.
REQ-014 SHALL have port GrantId  output  2  index of granted requester, 2'd3 when none.
REQ-015 SHALL have port Idle  output  1  high when no buffer is pending.

Function
REQ-016 SHALL hold one pending buffer per requester (valid flag, addr, data).
REQ-017 SHALL accept on ReqValid[i] & ReqReady[i] at a rising edge, capturing ReqAddr[i]/ReqData[i].
REQ-018 SHALL drive ReqReady[i] = !pending[i] | granted[i] (back-to-back accept while draining).
REQ-019 SHALL present a grant combinationally from pending buffers: accept at edge N -> RegWriteCtrl high in cycle N+1 -> register file written at edge N+1.
REQ-020 SHALL grant at most one requester per cycle, selected round-robin starting from pointer rr.
REQ-021 SHALL update rr to (granted index + 1) mod 3 on each grant edge; rr unchanged when no grant.
REQ-022 SHALL grant every pending buffer within 3 cycles with Freeze low (no starvation).
REQ-023 SHALL clear pending[i] on its grant edge unless a new accept into i occurs on the same edge, which reloads the buffer.
REQ-024 SHALL, with Freeze high, drive RegWriteCtrl=0, GrantId=3, hold all buffers and rr, and still accept into empty buffers.
REQ-025 SHALL drive WriteReg/WriteData from the granted buffer and 0 when RegWriteCtrl=0.
REQ-026 SHALL implement FSM IDLE (no pending) -> ACTIVE (any pending, Freeze low) <-> FROZEN (Freeze high, any pending); ACTIVE/FROZEN -> IDLE when last buffer drains with no accept.
REQ-027 SHALL drive Idle=1 only in IDLE.
REQ-028 SHALL permit two pending buffers with equal address; write order is grant order, the later grant wins.

Reset
REQ-029 SHALL, while Reset is high, clear all pending flags, set rr=0, FSM=IDLE, regardless of CLK.
REQ-030 SHALL drive during reset: ReqReady=3'b111 is not driven; ReqReady=0, RegWriteCtrl=0, LoadImm=0, WriteReg=0, WriteData=0, GrantId=3, Idle=1.
REQ-031 SHALL discard requests in flight when Reset asserts mid-operation; no write issued after deassertion for them.

Configuration
REQ-032 SHALL, with REGARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority IMM > MEM > ALU, rr removed, REQ-022 waived.
REQ-033 SHALL, without REGARB_FIXED_PRIO_EN, use round-robin per REQ-020..022.

Structure
REQ-034 SHALL place requester index constants (REQ_ALU=0, REQ_MEM=1, REQ_IMM=2, GRANT_NONE=3) and FSM state enum in package regarb_pkg.
REQ-035 SHALL implement selection as sub-module regarb_rr_select (pending, rr -> one-hot grant).

Verification
REQ-036 SHALL cover: single ALU request addr=2 data=10 -> cycle after accept RegWriteCtrl=1, WriteReg=2, WriteData=10, LoadImm=0, GrantId=0.
REQ-037 SHALL cover: all three valid same edge (addr 1,2,3; data 5,6,7), rr=0 -> grants ALU, MEM, IMM on consecutive cycles, LoadImm=1 only third cycle, Idle=1 after.
REQ-038 SHALL cover: Freeze high 4 cycles with MEM pending -> RegWriteCtrl=0 throughout, grant on first cycle after Freeze falls.
REQ-039 SHALL cover: ALU and IMM both addr=3, data 1 and 9 -> final register 3 equals data of later grant.
REQ-040 SHALL cover: Reset asserted asynchronously with 2 pending -> outputs at reset values before next CLK edge, no write after release.
REQ-041 SHALL cover: REGARB_FIXED_PRIO_EN build, ALU held valid continuously plus IMM pulses -> IMM granted each time it is pending.
